// File: rtl/stereo_signext_sched.sv
// Shares one registered 16->40-bit sign-extension unit between the left and right channels.
// Defining SIGNEXT_CHECK_EN adds a sticky ext_err output that flags a mismatching extender result.
module stereo_signext_sched #(
    parameter int EXT_LAT = 1
) (
    input  logic        Sclk,
    input  logic        Reset_n,
    input  logic        inL_valid,
    input  logic [15:0] inL_data,
    output logic        inL_ready,
    input  logic        inR_valid,
    input  logic [15:0] inR_data,
    output logic        inR_ready,
    output logic        ext_sign_status,
    output logic [15:0] ext_din,
    input  logic [39:0] ext_dout,
    output logic        out_valid,
    output logic [39:0] out_data,
    output logic        out_chan,
    input  logic        out_ready,
    output logic        busy,
    output logic        overrun_L,
    output logic        overrun_R
`ifdef SIGNEXT_CHECK_EN
    ,
    output logic        ext_err
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    localparam logic [2:0] LAT_M1 = 3'(EXT_LAT - 1);

    state_t      state_q;
    logic        full_l_q, full_r_q;
    logic [15:0] data_l_q, data_r_q;
    logic        last_grant_q;
    logic        work_chan_q;
    logic        ext_sign_q;
    logic [15:0] ext_din_q;
    logic [2:0]  cnt_q;
    logic        out_valid_q;
    logic [39:0] out_data_q;
    logic        out_chan_q;
    logic        ovr_l_q, ovr_r_q;

    logic        grant_d;
    logic        grant_r_d;
    logic [15:0] grant_data_d;

    // Round-robin: a tie goes to the channel that was not served last.
    always_comb begin
        grant_r_d    = full_r_q & (~full_l_q | ~last_grant_q);
        grant_data_d = grant_r_d ? data_r_q : data_l_q;
        grant_d      = (full_l_q | full_r_q) &
                       ((state_q == IDLE) | ((state_q == OUT) & out_ready));
    end

`ifdef SIGNEXT_CHECK_EN
    logic        ext_err_q;
    logic [39:0] ext_expect;
    assign ext_expect = {{8{ext_din_q[15]}}, ext_din_q, 16'h0000};
    assign ext_err    = ext_err_q;
`endif

    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            full_l_q     <= 1'b0;
            full_r_q     <= 1'b0;
            data_l_q     <= 16'h0000;
            data_r_q     <= 16'h0000;
            last_grant_q <= 1'b1;
            work_chan_q  <= 1'b0;
            ext_sign_q   <= 1'b0;
            ext_din_q    <= 16'h0000;
            cnt_q        <= 3'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 40'h0;
            out_chan_q   <= 1'b0;
            ovr_l_q      <= 1'b0;
            ovr_r_q      <= 1'b0;
`ifdef SIGNEXT_CHECK_EN
            ext_err_q    <= 1'b0;
`endif
        end else begin
            ovr_l_q    <= inL_valid & full_l_q;
            ovr_r_q    <= inR_valid & full_r_q;
            ext_sign_q <= 1'b0;

            if (inL_valid && !full_l_q) begin
                full_l_q <= 1'b1;
                data_l_q <= inL_data;
            end
            if (inR_valid && !full_r_q) begin
                full_r_q <= 1'b1;
                data_r_q <= inR_data;
            end

            // A grant only ever clears a full register, so it never races an accept.
            if (grant_d) begin
                if (grant_r_d) full_r_q <= 1'b0;
                else           full_l_q <= 1'b0;
                last_grant_q <= grant_r_d;
                work_chan_q  <= grant_r_d;
                ext_din_q    <= grant_data_d;
                ext_sign_q   <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (grant_d) state_q <= ISSUE;
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= LAT_M1;
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        out_data_q  <= ext_dout;
                        out_chan_q  <= work_chan_q;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
`ifdef SIGNEXT_CHECK_EN
                        if (ext_dout != ext_expect) ext_err_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= grant_d ? ISSUE : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inL_ready       = ~full_l_q;
    assign inR_ready       = ~full_r_q;
    assign ext_sign_status = ext_sign_q;
    assign ext_din         = ext_din_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_chan        = out_chan_q;
    assign busy            = (state_q != IDLE);
    assign overrun_L       = ovr_l_q;
    assign overrun_R       = ovr_r_q;

endmodule

// File: tb/tb_stereo_signext_sched.sv
// Scoreboard bench for stereo_signext_sched: per-channel expected queues, a monitor on the output
// handshake, a behavioural extender model, directed scenarios and a randomized traffic phase.
module tb_stereo_signext_sched;

    localparam int LAT = 1;

    logic        Sclk = 1'b0;
    logic        Reset_n;
    logic        inL_valid, inR_valid;
    logic [15:0] inL_data, inR_data;
    logic        inL_ready, inR_ready;
    logic        ext_sign_status;
    logic [15:0] ext_din;
    logic [39:0] ext_dout;
    logic        out_valid;
    logic [39:0] out_data;
    logic        out_chan;
    logic        out_ready;
    logic        busy, overrun_L, overrun_R;
`ifdef SIGNEXT_CHECK_EN
    logic        ext_err;
`endif

    stereo_signext_sched #(.EXT_LAT(LAT)) dut (
        .Sclk(Sclk), .Reset_n(Reset_n),
        .inL_valid(inL_valid), .inL_data(inL_data), .inL_ready(inL_ready),
        .inR_valid(inR_valid), .inR_data(inR_data), .inR_ready(inR_ready),
        .ext_sign_status(ext_sign_status), .ext_din(ext_din), .ext_dout(ext_dout),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_ready(out_ready),
        .busy(busy), .overrun_L(overrun_L), .overrun_R(overrun_R)
`ifdef SIGNEXT_CHECK_EN
        , .ext_err(ext_err)
`endif
    );

    always #5 Sclk = ~Sclk;

    typedef struct {
        logic [39:0] data;
        int          acc;
        bit          lat_chk;
    } exp_t;

    typedef struct {
        bit          chan;
        logic [39:0] data;
        int          cyc;
    } hs_t;

    exp_t        q_l[$];
    exp_t        q_r[$];
    hs_t         hs_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          lat_chk_en = 0;
    bit          pres = 0;
    logic [39:0] held_data;
    logic        held_chan;
    logic [39:0] corrupt_mask = 40'h0;
    int          rdy_mode = 0;   // 0 ready high, 1 ready low, 2 random

    // Sign extension into bits 39:16 expressed as signed arithmetic.
    function automatic logic [39:0] ext_ref(input logic [15:0] s);
        longint v;
        v = longint'($signed(s)) * 64'sd65536;
        return v[39:0];
    endfunction

    // Extender model: result appears LAT cycles after the strobe is sampled.
    logic [39:0] pipe [LAT];
    always @(posedge Sclk) begin
        if (ext_sign_status) pipe[0] <= ext_ref(ext_din);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ext_dout = pipe[LAT-1] ^ corrupt_mask;

    always @(posedge Sclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge Sclk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Recorder: a sample visible with valid&ready at the falling edge is taken at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge Sclk);
            if (Reset_n) begin
                if (inL_valid && inL_ready) begin
                    e.data = ext_ref(inL_data) ^ corrupt_mask; e.acc = cyc + 1; e.lat_chk = lat_chk_en;
                    q_l.push_back(e);
                end
                if (inR_valid && inR_ready) begin
                    e.data = ext_ref(inR_data) ^ corrupt_mask; e.acc = cyc + 1; e.lat_chk = lat_chk_en;
                    q_r.push_back(e);
                end
            end
        end
    end

    // Monitor: latency at first presentation, stability while stalled, data on handshake.
    initial begin
        exp_t e;
        hs_t  h;
        bit   have;
        forever begin
            @(negedge Sclk);
            if (!Reset_n) begin
                pres = 0;
            end else if (out_valid) begin
                have = out_chan ? (q_r.size() > 0) : (q_l.size() > 0);
                if (!pres) begin
                    pres = 1;
                    held_data = out_data;
                    held_chan = out_chan;
                    if (have) begin
                        e = out_chan ? q_r[0] : q_l[0];
                        if (e.lat_chk) chk("latency", 64'(cyc - e.acc), 64'(LAT + 2));
                    end
                end else begin
                    chk("hold_data", 64'(out_data), 64'(held_data));
                    chk("hold_chan", 64'(out_chan), 64'(held_chan));
                end
                if (out_ready) begin
                    pres = 0;
                    if (!have) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output chan=%0d actual=%h required=none", out_chan, out_data);
                    end else begin
                        e = out_chan ? q_r.pop_front() : q_l.pop_front();
                        chk(out_chan ? "data_R" : "data_L", 64'(out_data), 64'(e.data));
                    end
                    h.chan = out_chan; h.data = out_data; h.cyc = cyc;
                    hs_log.push_back(h);
                end
            end
        end
    end

    // Called away from the falling edge; returns 1 ns after the accepting rising edge.
    task automatic offer(input bit ch, input logic [15:0] d);
        int n;
        bit got;
        n = 0; got = 0;
        if (ch) begin inR_valid = 1'b1; inR_data = d; end
        else    begin inL_valid = 1'b1; inL_data = d; end
        while (!got && n < 300) begin
            @(negedge Sclk);
            n++;
            got = ch ? inR_ready : inL_ready;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL offer_timeout ch=%0d actual=not_accepted required=accepted", ch);
        end
        @(posedge Sclk); #1;
        if (ch) inR_valid = 1'b0; else inL_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bit done;
        n = 0; done = 0;
        while (!done && n < 1000) begin
            @(negedge Sclk);
            n++;
            done = (q_l.size() == 0) && (q_r.size() == 0) && !out_valid && !busy;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=pending_L%0d_R%0d required=empty", q_l.size(), q_r.size());
        end
        @(posedge Sclk); #1;
    endtask

    task automatic do_reset();
        @(posedge Sclk); #1;
        Reset_n = 1'b0;
        q_l.delete(); q_r.delete();
        repeat (2) @(posedge Sclk);
        #1;
        Reset_n = 1'b1;
        @(posedge Sclk); #1;
    endtask

    task automatic chk_hs(input int i, input bit ch, input logic [39:0] d);
        if (hs_log.size() <= i) begin
            checks++; errors++;
            $display("FAIL hs_missing index=%0d actual=%0d_entries required=more", i, hs_log.size());
        end else begin
            chk("hs_chan", 64'(hs_log[i].chan), 64'(ch));
            chk("hs_data", 64'(hs_log[i].data), 64'(d));
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge Sclk);
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL wait_valid_timeout actual=0 required=1");
        end
    endtask

    initial begin
        int i0;
        Reset_n = 1'b0;
        inL_valid = 1'b0; inR_valid = 1'b0;
        inL_data = 16'h0; inR_data = 16'h0;

        // Reset state
        repeat (3) @(negedge Sclk);
        chk("rst_inL_ready", 64'(inL_ready), 64'd1);
        chk("rst_inR_ready", 64'(inR_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ext_sign", 64'(ext_sign_status), 64'd0);
        chk("rst_overrun_L", 64'(overrun_L), 64'd0);
        chk("rst_overrun_R", 64'(overrun_R), 64'd0);
        @(posedge Sclk); #1;
        Reset_n = 1'b1;
        @(negedge Sclk);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_chan", 64'(out_chan), 64'd0);
        chk("rst_ext_din", 64'(ext_din), 64'd0);
        @(posedge Sclk); #1;

        // Single left sample, latency checked by the monitor
        lat_chk_en = 1;
        i0 = hs_log.size();
        offer(0, 16'h8001);
        lat_chk_en = 0;
        drain();
        chk_hs(i0, 0, 40'hFF80010000);

        // Simultaneous pairs from reset: left first both times
        do_reset();
        i0 = hs_log.size();
        fork
            offer(0, 16'h1234);
            offer(1, 16'hF000);
        join
        drain();
        fork
            offer(0, 16'h0042);
            offer(1, 16'h8000);
        join
        drain();
        chk_hs(i0,     0, 40'h0012340000);
        chk_hs(i0 + 1, 1, 40'hFFF0000000);
        chk_hs(i0 + 2, 0, 40'h0000420000);
        chk_hs(i0 + 3, 1, 40'hFF80000000);

        // Continuous traffic: alternation and LAT+2 spacing
        i0 = hs_log.size();
        fork
            for (int k = 0; k < 8; k++) offer(0, 16'($urandom));
            for (int k = 0; k < 8; k++) offer(1, 16'($urandom));
        join
        drain();
        if (hs_log.size() < i0 + 16) begin
            checks++; errors++;
            $display("FAIL stream_count actual=%0d required=16", hs_log.size() - i0);
        end else begin
            chk("stream_first", 64'(hs_log[i0].chan), 64'd0);
            for (int j = 1; j < 16; j++) begin
                chk("stream_alt", 64'(hs_log[i0 + j].chan), 64'(j % 2));
                chk("stream_spacing", 64'(hs_log[i0 + j].cyc - hs_log[i0 + j - 1].cyc), 64'(LAT + 2));
            end
        end

        // Backpressure: hold OUT, fill both holding registers, provoke an overrun
        rdy_mode = 1;
        @(posedge Sclk); #1;
        @(posedge Sclk); #1;
        i0 = hs_log.size();
        offer(0, 16'h4321);
        wait_valid();
        @(posedge Sclk); #1;
        offer(1, 16'h9ABC);
        offer(0, 16'h0FFF);
        @(negedge Sclk);
        chk("bp_inL_ready", 64'(inL_ready), 64'd0);
        chk("bp_inR_ready", 64'(inR_ready), 64'd0);
        repeat (6) begin
            @(negedge Sclk);
            chk("bp_ext_sign", 64'(ext_sign_status), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge Sclk); #1;
        inL_valid = 1'b1; inL_data = 16'hDEAD;
        @(posedge Sclk); #1;
        inL_valid = 1'b0;
        @(negedge Sclk);
        chk("overrun_L_pulse", 64'(overrun_L), 64'd1);
        chk("overrun_R_quiet", 64'(overrun_R), 64'd0);
        @(negedge Sclk);
        chk("overrun_L_end", 64'(overrun_L), 64'd0);
        rdy_mode = 0;
        @(posedge Sclk); #1;
        drain();
        chk_hs(i0,     0, 40'h0043210000);
        chk_hs(i0 + 1, 1, 40'hFF9ABC0000);
        chk_hs(i0 + 2, 0, 40'h000FFF0000);

        // Reset while waiting on the extender
        offer(0, 16'h7FFF);
        @(posedge Sclk); #1;
        @(negedge Sclk);
        chk("issue_strobe", 64'(ext_sign_status), 64'd1);
        chk("issue_din", 64'(ext_din), 64'h7FFF);
        chk("issue_busy", 64'(busy), 64'd1);
        @(posedge Sclk); #1;
        Reset_n = 1'b0;
        q_l.delete(); q_r.delete();
        @(negedge Sclk);
        chk("wrst_out_valid", 64'(out_valid), 64'd0);
        chk("wrst_busy", 64'(busy), 64'd0);
        chk("wrst_inL_ready", 64'(inL_ready), 64'd1);
        chk("wrst_inR_ready", 64'(inR_ready), 64'd1);
        @(posedge Sclk); #1;
        Reset_n = 1'b1;
        @(posedge Sclk); #1;
        i0 = hs_log.size();
        fork
            offer(0, 16'h0001);
            offer(1, 16'hFFFF);
        join
        drain();
        chk_hs(i0,     0, 40'h0000010000);
        chk_hs(i0 + 1, 1, 40'hFFFFFF0000);

`ifdef SIGNEXT_CHECK_EN
        chk("ext_err_clear", 64'(ext_err), 64'd0);
        corrupt_mask = 40'h0000100000;
        offer(0, 16'h1357);
        drain();
        corrupt_mask = 40'h0;
        chk("ext_err_set", 64'(ext_err), 64'd1);
        offer(1, 16'h2468);
        drain();
        chk("ext_err_sticky", 64'(ext_err), 64'd1);
`endif

        // Randomized traffic with random downstream stalls
        rdy_mode = 2;
        fork
            for (int k = 0; k < 30; k++) begin
                offer(0, 16'($urandom));
                repeat ($urandom_range(0, 4)) @(posedge Sclk);
                #1;
            end
            for (int k = 0; k < 30; k++) begin
                offer(1, 16'($urandom));
                repeat ($urandom_range(0, 4)) @(posedge Sclk);
                #1;
            end
        join
        rdy_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stereo_signext_sched.md
Name: stereo_signext_sched

Overview:
- Sequencer/arbiter that shares one registered 16->40-bit sign-extension unit between the left and right audio channels.
- Buffers one sample per channel and arbitrates round-robin between L and R.
- Drives the extender's sign-status strobe and data input, captures the 40-bit result after a fixed latency, and presents it downstream with a channel tag over a valid/ready handshake.
- Sits between the serial-input deserialiser and the 40-bit MAC/filter datapath.

Parameters:
EXT_LAT, 1, extender latency in Sclk cycles from strobe edge to valid result (1..7)

Ports:
Sclk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
inL_valid  input  1  left sample offered
inL_data  input  16  left sample, two's complement
inL_ready  output  1  left holding register empty
inR_valid  input  1  right sample offered
inR_data  input  16  right sample
inR_ready  output  1  right holding register empty
ext_sign_status  output  1  extender load strobe
ext_din  output  16  sample to extender
ext_dout  input  40  extender result
out_valid  output  1  result available
out_data  output  40  extended sample
out_chan  output  1  0=left, 1=right
out_ready  input  1  downstream accepts
busy  output  1  FSM not IDLE
overrun_L  output  1  one-cycle pulse: inL_valid while inL_ready=0
overrun_R  output  1  same, right

Behaviour:
- Reset (async assert, sync release): all outputs 0 except inL_ready=inR_ready=1; holding regs empty; FSM=IDLE; last_grant=R, so L wins the first tie. Any in-flight sample is discarded.
- Holding regs: inX_ready = !fullX, combinational from register. Transfer on valid&ready at a clock edge sets fullX. valid with ready low is not accepted; it pulses overrun_X in that cycle (registered, asserted next cycle). The sample is dropped.
- Arbiter (evaluated in IDLE, and in OUT on handshake):
  - Only one channel full -> grant it.
  - Both full -> grant !last_grant.
  - Grant loads the work reg, clears fullX at the same edge (ready rises next cycle), and updates last_grant.
- FSM:
  - IDLE: on grant -> ISSUE.
  - ISSUE (1 cycle): ext_sign_status=1, ext_din=work sample. Otherwise ext_sign_status=0 and ext_din holds its last value. -> WAIT.
  - WAIT: counter counts EXT_LAT cycles. On the last one, capture ext_dout into out_data and the channel into out_chan. -> OUT.
  - OUT: out_valid=1. out_data and out_chan must stay stable until out_valid&out_ready. On handshake: if a grant is available -> ISSUE; else -> IDLE.
- Latency: accept at edge k -> ISSUE in cycle k+1 -> out_valid in cycle k+2+EXT_LAT (k+3 when EXT_LAT=1). Back-to-back throughput is one sample per EXT_LAT+2 cycles.
- Backpressure: out_ready low holds OUT indefinitely. No new ISSUE. Holding regs continue to accept until full.
- Simultaneous events:
  - Accept and grant on the same channel in one cycle cannot occur, because ready is low while full.
  - Handshake and new arrival in the same cycle: the arrival is visible to the arbiter one cycle later.
- out_data is passed through unmodified. Expected value is {8{s[15]}, s, 16'h0000}.

Optional Feature:
- Macro: SIGNEXT_CHECK_EN.
- When defined: adds output ext_err (1 bit, reset 0), sticky until Reset_n. It is set if, at WAIT capture, ext_dout differs from {8{s[15]}, s, 16'h0000} for the issued sample s.
- When undefined: port and compare logic are absent; behaviour is otherwise identical.

Test Plan:
1. inL_data=16'h8001 alone, out_ready=1, EXT_LAT=1 -> out_valid 3 cycles after accept, out_data=40'hFF80010000, out_chan=0.
2. L=16'h1234 and R=16'hF000 accepted the same edge -> outputs L (40'h0012340000) then R (40'hFFF0000000). A second simultaneous pair also returns L first, because last_grant=R after the first pair.
3. Continuous L and R traffic -> out_chan alternates 0,1,0,1. Spacing between out_valid handshakes = 3 cycles.
4. out_ready=0 for 6 cycles during OUT -> out_data/out_chan stable, ext_sign_status stays 0. Both inX_ready drop after fill. inL_valid held -> overrun_L pulses.
5. Reset_n asserted during WAIT -> next cycle out_valid=0, busy=0, inL_ready=inR_ready=1. After release, a tie is granted to L.
6. EXT_LAT=3 with model extender -> out_valid 5 cycles after accept. With SIGNEXT_CHECK_EN and a corrupted ext_dout bit, ext_err=1 and stays set.
